multi_cycle_mem: RTL

Word-organised data/instruction memory that sits directly downstream of the multi-cycle MIPS core's memory port. It consumes `mem_addr`, `mem_read`, `mem_write` and `mem_write_data`, and produces `mem_read_data` with a fixed, parameterised read latency matching the core's FETCH1–FETCH3 and EX_LW_2–EX_LW_4 wait states. It also provides a backdoor load port for program images, a busy/valid indication and a sticky access-error flag.

---
 rtl/multi_cycle_mem.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_mem.sv
// multi_cycle_mem: word-organised memory for the multi-cycle MIPS core.
// Fixed, parameterised read latency, a backdoor load port for program images,
// busy/valid handshake outputs and a sticky access-error flag.
module multi_cycle_mem #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           mem_addr,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           mem_write_data,
    output logic [31:0]           mem_read_data,
    output logic                  mem_busy,
    output logic                  mem_rvalid,
    output logic                  mem_error,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [31:0]           ld_data
);

    localparam int unsigned Words = 2 ** ADDR_WIDTH;

    // WAIT-state countdown start; WAIT is skipped entirely when READ_LATENCY is 1.
    localparam logic [1:0] CntInit = (READ_LATENCY >= 2) ? 2'(READ_LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHold
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
    logic                    rbad_q, rbad_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [31:0]             mem_q [Words];

    logic [ADDR_WIDTH-1:0]   word_addr;
    logic                    addr_misaligned;
    logic                    addr_oor;
    logic                    addr_bad;
    logic                    wr_good;

    logic                    arm;
    logic                    load;
    logic                    load_bad;
    logic [ADDR_WIDTH-1:0]   load_addr;
    logic                    err_set;

    // Classify the current CPU address as good or bad.
    always_comb begin
        word_addr       = mem_addr[ADDR_WIDTH+1:2];
        addr_misaligned = |mem_addr[1:0];
        addr_oor        = |(mem_addr >> (ADDR_WIDTH + 2));
        addr_bad        = addr_misaligned | addr_oor;
        wr_good         = mem_write & ~addr_bad;
    end

    // Storage array; not reset. CPU write is ordered last so it wins a same-word collision.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem_q[ld_addr] <= ld_data;
        end
        if (wr_good) begin
            mem_q[word_addr] <= mem_write_data;
        end
    end

    // Next-state logic for the read FSM, read-data register and error flag.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        raddr_d   = raddr_q;
        rbad_d    = rbad_q;
        arm       = 1'b0;
        load      = 1'b0;
        load_addr = raddr_q;
        load_bad  = rbad_q;
        err_set   = mem_write & addr_bad;

        unique case (state_q)
            StIdle: begin
                if (mem_read) begin
                    // Simultaneous write+read: write goes ahead, read is refused.
                    if (mem_write) begin
                        err_set = 1'b1;
                    end else begin
                        arm = 1'b1;
                    end
                end
            end
            StWait: begin
                if (!mem_read) begin
                    state_d = StIdle;
                end else if (cnt_q == 2'd0) begin
                    load    = 1'b1;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StHold: begin
                if (!mem_read) begin
                    state_d = StIdle;
                end else if (word_addr != raddr_q) begin
                    // New request while holding; same conflict rule as from idle.
                    if (mem_write) begin
                        err_set = 1'b1;
                        state_d = StIdle;
                    end else begin
                        arm = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (arm) begin
            raddr_d = word_addr;
            rbad_d  = addr_bad;
            if (addr_bad) begin
                err_set = 1'b1;
            end
            if (READ_LATENCY == 1) begin
                load      = 1'b1;
                load_addr = word_addr;
                load_bad  = addr_bad;
                state_d   = StHold;
            end else begin
                cnt_d   = CntInit;
                state_d = StWait;
            end
        end

        rdata_d = rdata_q;
        if (load) begin
            rdata_d = load_bad ? 32'h0000_0000 : mem_q[load_addr];
        end

        err_d = err_q | err_set;
    end

    // State and output registers; a pending read is discarded on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            raddr_q <= '0;
            rbad_q  <= 1'b0;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            raddr_q <= raddr_d;
            rbad_q  <= rbad_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Output decode straight from the registered state.
    always_comb begin
        mem_read_data = rdata_q;
        mem_busy      = (state_q == StWait);
        mem_rvalid    = (state_q == StHold);
        mem_error     = err_q;
    end

endmodule
